// File: rtl/ps2_scancode_decoder_pkg.sv
// Shared definitions for the PS/2 Set-2 scancode decoder: FSM state codes,
// prefix byte constants, the event record and the control-byte classifier.
package ps2_scancode_pkg;

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_EXT     = 3'd1;
   localparam logic [2:0] ST_BRK     = 3'd2;
   localparam logic [2:0] ST_EXT_BRK = 3'd3;
   localparam logic [2:0] ST_PAUSE   = 3'd4;

   localparam logic [7:0] PS2_PREFIX_EXT   = 8'hE0;
   localparam logic [7:0] PS2_PREFIX_BRK   = 8'hF0;
   localparam logic [7:0] PS2_PREFIX_PAUSE = 8'hE1;
   localparam logic [7:0] PS2_PAUSE_CODE   = 8'h77;
   localparam logic [2:0] PS2_PAUSE_TAIL   = 3'd7;

   typedef struct packed {
      logic       ext;
      logic       rel;
      logic [7:0] code;
   } ps2_event_t;

   // Keyboard replies and self-test/error bytes that never form part of a key event.
   function automatic logic is_ctrl_byte(input logic [7:0] b);
      case (b)
         8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF: is_ctrl_byte = 1'b1;
         default:                                         is_ctrl_byte = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/ps2_scancode_decoder_if.sv
// Byte-in / event-out bus of the scancode decoder. The decoder uses the master
// modport; the event consumer (and the receive stage feeding bytes) the slave.
interface ps2_scancode_decoder_if #(
   parameter int FIFO_ADDR_W = 3
);
   logic [7:0]           received_data;
   logic                 received_data_en;
   logic                 event_read;
   logic                 clear_overflow;
   logic                 event_valid;
   logic [7:0]           event_code;
   logic                 event_extended;
   logic                 event_released;
   logic [FIFO_ADDR_W:0] event_count;
   logic                 overflow;

   modport master (
      input  received_data, received_data_en, event_read, clear_overflow,
      output event_valid, event_code, event_extended, event_released,
             event_count, overflow
   );

   modport slave (
      output received_data, received_data_en, event_read, clear_overflow,
      input  event_valid, event_code, event_extended, event_released,
             event_count, overflow
   );
endinterface

// File: rtl/ps2_scancode_decoder_fifo.sv
// First-word-fall-through event FIFO. When empty the head output keeps the last
// popped entry (zero after reset) so the consumer never sees stale RAM contents.
module ps2_event_fifo #(
   parameter int FIFO_DEPTH  = 8,
   parameter int FIFO_ADDR_W = 3,
   parameter int WIDTH       = 10
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 push,
   input  logic [WIDTH-1:0]     push_data,
   input  logic                 pop_req,
   output logic [WIDTH-1:0]     head_data,
   output logic                 empty,
   output logic [FIFO_ADDR_W:0] count,
   output logic                 drop
);

   logic [WIDTH-1:0]       mem [FIFO_DEPTH];
   logic [FIFO_ADDR_W-1:0] wr_ptr;
   logic [FIFO_ADDR_W-1:0] rd_ptr;
   logic [FIFO_ADDR_W:0]   count_q;
   logic [WIDTH-1:0]       last_q;
   logic                   full;
   logic                   do_pop;
   logic                   do_push;

   // Depth is a power of two, so the count MSB alone marks "full".
   assign empty   = (count_q == '0);
   assign full    = count_q[FIFO_ADDR_W];
   assign do_pop  = pop_req & ~empty;
   assign do_push = push & (~full | do_pop);
   assign drop    = push & full & ~do_pop;
   assign count   = count_q;
   assign head_data = empty ? last_q : mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
         last_q  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
            last_q <= mem[rd_ptr];
         end
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/ps2_scancode_decoder.sv
// Folds PS/2 Set-2 prefix sequences (E0, F0, E0 F0, E1 Pause) into single key
// events and queues them in a FWFT FIFO with a sticky overflow flag.
module ps2_scancode_decoder
   import ps2_scancode_pkg::*;
#(
   parameter int FIFO_DEPTH  = 8,
   parameter int FIFO_ADDR_W = 3
) (
   input  logic                  clk,
   input  logic                  reset,
   ps2_scancode_decoder_if.master bus
);

   logic [2:0]           state;
   logic [2:0]           state_nxt;
   logic [2:0]           pause_cnt;
   logic [2:0]           pause_cnt_nxt;
   logic                 push;
   ps2_event_t           push_ev;
   ps2_event_t           head_ev;
   logic [9:0]           head_data;
   logic                 fifo_empty;
   logic [FIFO_ADDR_W:0] fifo_count;
   logic                 fifo_drop;
   logic                 overflow_q;
   logic [7:0]           b;

   assign b = bus.received_data;

   always_comb begin
      state_nxt     = state;
      pause_cnt_nxt = pause_cnt;
      push          = 1'b0;
      push_ev       = '0;
      if (bus.received_data_en) begin
         if (state == ST_PAUSE) begin
            // The Pause tail is opaque: its bytes look like prefixes and codes.
            pause_cnt_nxt = pause_cnt - 1'b1;
            if (pause_cnt == 3'd1) begin
               push         = 1'b1;
               push_ev.ext  = 1'b1;
               push_ev.code = PS2_PAUSE_CODE;
               state_nxt    = ST_IDLE;
            end
         end else if (is_ctrl_byte(b)) begin
            state_nxt = ST_IDLE;
         end else if (b == PS2_PREFIX_PAUSE) begin
            state_nxt     = ST_PAUSE;
            pause_cnt_nxt = PS2_PAUSE_TAIL;
         end else if (b == PS2_PREFIX_EXT) begin
            state_nxt = ST_EXT;
         end else if (b == PS2_PREFIX_BRK) begin
            state_nxt = (state == ST_EXT || state == ST_EXT_BRK) ? ST_EXT_BRK : ST_BRK;
         end else begin
            push         = 1'b1;
            push_ev.ext  = (state == ST_EXT) || (state == ST_EXT_BRK);
            push_ev.rel  = (state == ST_BRK) || (state == ST_EXT_BRK);
            push_ev.code = b;
            state_nxt    = ST_IDLE;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= ST_IDLE;
         pause_cnt  <= '0;
         overflow_q <= 1'b0;
      end else begin
         state     <= state_nxt;
         pause_cnt <= pause_cnt_nxt;
         if (fifo_drop)               overflow_q <= 1'b1;
         else if (bus.clear_overflow) overflow_q <= 1'b0;
      end
   end

   ps2_event_fifo #(
      .FIFO_DEPTH  (FIFO_DEPTH),
      .FIFO_ADDR_W (FIFO_ADDR_W),
      .WIDTH       (10)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push),
      .push_data (push_ev),
      .pop_req   (bus.event_read),
      .head_data (head_data),
      .empty     (fifo_empty),
      .count     (fifo_count),
      .drop      (fifo_drop)
   );

   assign head_ev            = head_data;
   assign bus.event_valid    = ~fifo_empty;
   assign bus.event_code     = head_ev.code;
   assign bus.event_extended = head_ev.ext;
   assign bus.event_released = head_ev.rel;
   assign bus.event_count    = fifo_count;
   assign bus.overflow       = overflow_q;

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Directed bench for ps2_scancode_decoder: a table of byte sequences with their
// expected events, plus hand-written overflow, clear-priority and reset sequences.
module tb_ps2_scancode_decoder;

   localparam int FIFO_DEPTH  = 8;
   localparam int FIFO_ADDR_W = 3;
   localparam int NV          = 7;

   typedef struct {
      int               nb;
      logic [0:7][7:0]  b;
      int               ne;
      logic [0:2][9:0]  ev;
   } vec_t;

   logic clk = 1'b0;
   logic reset = 1'b0;
   int   n_cmp = 0;
   int   n_fail = 0;
   vec_t vec [NV];

   always #5 clk = ~clk;

   ps2_scancode_decoder_if #(.FIFO_ADDR_W(FIFO_ADDR_W)) bus ();

   ps2_scancode_decoder #(
      .FIFO_DEPTH  (FIFO_DEPTH),
      .FIFO_ADDR_W (FIFO_ADDR_W)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   function automatic logic [9:0] head();
      return {bus.event_extended, bus.event_released, bus.event_code};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] v);
      @(negedge clk);
      bus.received_data    = v;
      bus.received_data_en = 1'b1;
      @(negedge clk);
      bus.received_data_en = 1'b0;
   endtask

   task automatic pop_expect(input string name, input logic [9:0] exp);
      check({name, " valid"}, 32'(bus.event_valid), 32'd1);
      check({name, " head"}, 32'(head()), 32'(exp));
      bus.event_read = 1'b1;
      @(negedge clk);
      bus.event_read = 1'b0;
   endtask

   initial begin
      bus.received_data    = 8'h00;
      bus.received_data_en = 1'b0;
      bus.event_read       = 1'b0;
      bus.clear_overflow   = 1'b0;

      vec[0] = '{3, {8'h1C, 8'hF0, 8'h1C, 40'h0}, 2, {10'h01C, 10'h11C, 10'h0}};
      vec[1] = '{5, {8'hE0, 8'h75, 8'hE0, 8'hF0, 8'h75, 24'h0}, 2, {10'h275, 10'h375, 10'h0}};
      vec[2] = '{4, {8'hE0, 8'h12, 8'hE0, 8'h7C, 32'h0}, 2, {10'h212, 10'h27C, 10'h0}};
      vec[3] = '{8, {8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77}, 1, {10'h277, 20'h0}};
      vec[4] = '{4, {8'hAA, 8'hF0, 8'hFA, 8'h1C, 32'h0}, 1, {10'h01C, 20'h0}};
      vec[5] = '{5, {8'hF0, 8'hE0, 8'hF0, 8'hE0, 8'h5A, 24'h0}, 1, {10'h25A, 20'h0}};
      vec[6] = '{5, {8'hE0, 8'hE0, 8'hF0, 8'hF0, 8'h11, 24'h0}, 1, {10'h311, 20'h0}};

      // Reset state
      repeat (2) @(negedge clk);
      check("rst valid", 32'(bus.event_valid), 32'd0);
      check("rst head", 32'(head()), 32'd0);
      check("rst count", 32'(bus.event_count), 32'd0);
      check("rst overflow", 32'(bus.overflow), 32'd0);
      reset = 1'b1;
      repeat (2) @(negedge clk);

      // First strobe: valid rises one cycle later
      bus.received_data    = 8'h1C;
      bus.received_data_en = 1'b1;
      #1 check("strobe cycle valid", 32'(bus.event_valid), 32'd0);
      @(negedge clk);
      bus.received_data_en = 1'b0;
      check("valid after strobe", 32'(bus.event_valid), 32'd1);
      check("first head", 32'(head()), 32'h01C);
      repeat (9) @(negedge clk);
      send_byte(8'hF0);
      repeat (9) @(negedge clk);
      send_byte(8'h1C);
      check("two events count", 32'(bus.event_count), 32'd2);
      pop_expect("first make", 10'h01C);
      pop_expect("first break", 10'h11C);
      check("drained valid", 32'(bus.event_valid), 32'd0);
      check("hold last popped", 32'(head()), 32'h11C);

      // Table-driven sequences
      for (int v = 0; v < NV; v++) begin
         for (int i = 0; i < vec[v].nb; i++) send_byte(vec[v].b[i]);
         repeat (2) @(negedge clk);
         check($sformatf("vec%0d count", v), 32'(bus.event_count), 32'(vec[v].ne));
         for (int e = 0; e < vec[v].ne; e++)
            pop_expect($sformatf("vec%0d ev%0d", v, e), vec[v].ev[e]);
         check($sformatf("vec%0d empty", v), 32'(bus.event_valid), 32'd0);
      end

      // Pop request on an empty FIFO is ignored
      bus.event_read = 1'b1;
      @(negedge clk);
      bus.event_read = 1'b0;
      check("empty pop count", 32'(bus.event_count), 32'd0);

      // Overflow: 9 pushes into 8 slots
      for (int i = 1; i <= 9; i++) send_byte(8'(i));
      check("full count", 32'(bus.event_count), 32'd8);
      check("overflow set", 32'(bus.overflow), 32'd1);
      check("full head", 32'(head()), 32'h001);

      // Push and pop together while full
      @(negedge clk);
      bus.received_data    = 8'h0A;
      bus.received_data_en = 1'b1;
      bus.event_read       = 1'b1;
      @(negedge clk);
      bus.received_data_en = 1'b0;
      bus.event_read       = 1'b0;
      check("full rw count", 32'(bus.event_count), 32'd8);
      check("full rw overflow", 32'(bus.overflow), 32'd1);

      bus.clear_overflow = 1'b1;
      @(negedge clk);
      bus.clear_overflow = 1'b0;
      check("overflow cleared", 32'(bus.overflow), 32'd0);

      for (int i = 2; i <= 8; i++) pop_expect($sformatf("drain %0d", i), 10'(i));
      pop_expect("drain 0A", 10'h00A);
      check("drained count", 32'(bus.event_count), 32'd0);

      // New overflow wins over clear in the same cycle
      for (int i = 0; i < 8; i++) send_byte(8'h11 + 8'(i));
      @(negedge clk);
      bus.received_data    = 8'h19;
      bus.received_data_en = 1'b1;
      bus.clear_overflow   = 1'b1;
      @(negedge clk);
      bus.received_data_en = 1'b0;
      bus.clear_overflow   = 1'b0;
      check("overflow priority", 32'(bus.overflow), 32'd1);
      check("priority count", 32'(bus.event_count), 32'd8);
      check("priority head", 32'(head()), 32'h011);

      // Asynchronous reset mid-sequence with events queued
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      send_byte(8'h01);
      send_byte(8'h02);
      send_byte(8'h03);
      send_byte(8'hE0);
      send_byte(8'hF0);
      check("pre-reset count", 32'(bus.event_count), 32'd3);
      #2 reset = 1'b0;
      #1;
      check("async rst valid", 32'(bus.event_valid), 32'd0);
      check("async rst count", 32'(bus.event_count), 32'd0);
      check("async rst head", 32'(head()), 32'd0);
      check("async rst overflow", 32'(bus.overflow), 32'd0);
      @(negedge clk);
      reset = 1'b1;
      send_byte(8'h75);
      check("post-reset count", 32'(bus.event_count), 32'd1);
      pop_expect("post-reset event", 10'h075);

      repeat (2) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/ps2_scancode_decoder.md
Name: ps2_scancode_decoder

Overview:
- Consumes the byte stream from the PS/2 receive stage (received_data / received_data_en) and folds Set-2 prefix sequences into single key events.
- Prefix sequences handled: E0 extended, F0 break, E0 F0 extended break, and the 8-byte E1 Pause sequence.
- Decoded events are buffered in a small first-word-fall-through FIFO so a slow consumer (CPU port, demo display logic) can drain them with a valid/read handshake.

Parameters:
FIFO_DEPTH, 8, number of buffered events; power of two, minimum 2.
FIFO_ADDR_W, 3, log2(FIFO_DEPTH).

Ports:
clk  in  1  system clock; same domain as the PS/2 receive stage.
reset  in  1  asynchronous, active-low reset.
received_data  in  8  byte from the receive stage; sampled only when received_data_en=1.
received_data_en  in  1  one-cycle strobe: new byte available.
event_read  in  1  pop head event; ignored when event_valid=0.
clear_overflow  in  1  clears the overflow flag.
event_valid  out  1  FIFO not empty; head event is on event_* outputs.
event_code  out  8  head event make code.
event_extended  out  1  head event was E0-prefixed, or is Pause.
event_released  out  1  head event was a break (F0).
event_count  out  FIFO_ADDR_W+1  number of events stored.
overflow  out  1  sticky; an event was dropped because the FIFO was full.

Behaviour:
- Reset (reset=0, asynchronous): decoder state=IDLE, pause counter=0, FIFO empty, event_valid=0, event_code=0, event_extended=0, event_released=0, event_count=0, overflow=0. A sequence in progress when reset asserts is discarded.
- Bytes are processed only on cycles where received_data_en=1. All other cycles leave state and counter unchanged.
- Control bytes are dropped and return the decoder to IDLE from any state except PAUSE. Control bytes: 00, AA, EE, FA, FC, FE, FF.
- Decoder states and transitions:
  - IDLE:
    - E0 -> EXT.
    - F0 -> BRK.
    - E1 -> PAUSE, counter=7.
    - Other -> push {ext=0, rel=0, code=byte}; stay in IDLE.
  - EXT:
    - F0 -> EXT_BRK.
    - E0 -> stay in EXT.
    - E1 -> PAUSE, counter=7.
    - Other -> push {1, 0, byte}; go to IDLE.
  - BRK:
    - E0 -> EXT (sequence restarts).
    - F0 -> stay in BRK.
    - E1 -> PAUSE, counter=7.
    - Other -> push {0, 1, byte}; go to IDLE.
  - EXT_BRK:
    - E0 -> EXT.
    - F0 -> stay in EXT_BRK.
    - E1 -> PAUSE, counter=7.
    - Other -> push {1, 1, byte}; go to IDLE.
  - PAUSE:
    - Every byte is consumed regardless of value and decrements the counter.
    - When a byte arrives with counter=1: push {1, 0, 8'h77}; go to IDLE.
- Latency: a push decided in cycle N is written at the rising edge ending cycle N. event_valid is high in cycle N+1 if the FIFO was empty.
- FIFO: FIFO_DEPTH entries of 10 bits {ext, rel, code}. Head is always presented on event_*. When empty, event_* hold the last popped value, or 0 after reset.
- Pop occurs when event_read=1 and event_valid=1.
- Push and pop in the same cycle:
  - Non-empty FIFO: both happen; count unchanged.
  - Empty FIFO: push only.
  - Full FIFO: both happen; no overflow.
- Push while full with no pop: the event is dropped, overflow is set, and FIFO contents are unchanged.
- overflow priority: a new overflow in the same cycle as clear_overflow leaves overflow=1.
- Pointers wrap modulo FIFO_DEPTH. event_count ranges 0..FIFO_DEPTH.

Decomposition:
- Package ps2_scancode_pkg holds:
  - Decoder state encoding: IDLE, EXT, BRK, EXT_BRK, PAUSE (3 bits).
  - Byte constants: PS2_PREFIX_EXT=8'hE0, PS2_PREFIX_BRK=8'hF0, PS2_PREFIX_PAUSE=8'hE1, PS2_PAUSE_CODE=8'h77, PS2_PAUSE_TAIL=7.
  - A function identifying control bytes.
- Sub-module ps2_event_fifo: the FWFT FIFO (width 10, FIFO_DEPTH/FIFO_ADDR_W parameters, count, full/empty). The decoder FSM stays in the top module.

Test Plan:
- Bytes 1C; F0 1C (each a one-cycle strobe, 10 cycles apart) -> two events {1C, ext=0, rel=0} then {1C, ext=0, rel=1}; event_valid high 1 cycle after the first strobe; event_count=2.
- E0 75; E0 F0 75 -> {75, 1, 0} then {75, 1, 1}. Also E0 12 E0 7C -> {12, 1, 0}, {7C, 1, 0}.
- E1 14 77 E1 F0 14 F0 77 -> exactly one event {77, 1, 0}, pushed on the 8th byte; no events for the inner bytes.
- Byte AA, then F0 FA 1C -> no event for AA; FA aborts the break, giving {1C, 0, 0}.
- 9 make codes 01..09 with FIFO_DEPTH=8 and no reads:
  - FIFO holds 01..08, event_count=8, overflow=1.
  - Then read and push in the same cycle -> count stays 8, overflow unchanged.
  - clear_overflow -> overflow=0.
  - Draining with event_read yields 02..08 then 0A (the byte pushed during the simultaneous read).
- reset=0 asserted mid-cycle after E0 F0 with 3 events queued -> outputs clear immediately. After release, byte 75 -> {75, 0, 0}: the partial prefix was lost.
